// File: rtl/if_fetch_queue_stage.sv
// ------------------------------------------------------------------------------------------------
// if_fetch_queue_stage
//
// Superscalar instruction-fetch stage. Issues aligned FetchW-wide bundle reads to instruction
// memory, buffers the returned bundles in a Depth-entry queue and hands them to decode over a
// valid/ready handshake. Jump/branch redirects flush the queue and drop any in-flight response.
// A misaligned redirect target produces a per-slot valid mask that blanks the slots below the
// target word in the first bundle fetched after the redirect.
//
// Ports
//   clk_i              rising-edge clock
//   rst_ni             asynchronous active-low reset
//   en_i               fetch enable; 0 holds the PC and issues nothing
//   branch_taken_i     redirect to branch_address_i
//   branch_address_i   branch target (word aligned)
//   jump_i             redirect to jump_address_i; wins over branch_taken_i
//   jump_address_i     jump target (word aligned)
//   imem_req_o         read request this cycle
//   imem_addr_o        bundle-aligned read address
//   imem_rdata_i       bundle data, slot i in bits [32i+31:32i], valid the cycle after the request
//   out_valid_o        head bundle available
//   out_ready_i        decode accepts the head bundle
//   out_pc_o           aligned base PC of the head bundle
//   out_pc_next_o      out_pc_o + 4*FetchW (modulo 2^PcW)
//   out_instr_o        head bundle instructions
//   out_slot_valid_o   per-slot valid mask of the head bundle
// All out_* outputs read zero whenever out_valid_o is low.
// ------------------------------------------------------------------------------------------------
module if_fetch_queue_stage #(
  parameter int unsigned   PcW     = 10,
  parameter int unsigned   FetchW  = 2,
  parameter int unsigned   Depth   = 4,
  parameter logic [PcW-1:0] ResetPc = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                branch_taken_i,
  input  logic [PcW-1:0]      branch_address_i,
  input  logic                jump_i,
  input  logic [PcW-1:0]      jump_address_i,
  output logic                imem_req_o,
  output logic [PcW-1:0]      imem_addr_o,
  input  logic [FetchW*32-1:0] imem_rdata_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [PcW-1:0]      out_pc_o,
  output logic [PcW-1:0]      out_pc_next_o,
  output logic [FetchW*32-1:0] out_instr_o,
  output logic [FetchW-1:0]   out_slot_valid_o
);

  localparam int unsigned    BundleBytes = 4 * FetchW;
  localparam int unsigned    OffW        = $clog2(BundleBytes);
  localparam int unsigned    PtrW        = $clog2(Depth);
  localparam int unsigned    CntW        = $clog2(Depth + 1);
  localparam logic [PcW-1:0] BundleInc   = PcW'(BundleBytes);
  localparam logic [PcW-1:0] AlignMask   = ~PcW'(BundleBytes - 1);
  localparam logic [CntW-1:0] DepthCnt   = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr    = PtrW'(Depth - 1);

  // Circular pointer increment; Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // ----------------------------------------------------------------------------------------------
  // State
  // ----------------------------------------------------------------------------------------------
  logic [PcW-1:0]    pc_q, pc_d;
  logic [FetchW-1:0] skip_q, skip_d;          // slots to blank in the next issued bundle
  logic              inflight_q, inflight_d;
  logic [PcW-1:0]    req_pc_q, req_pc_d;      // PC of the outstanding request
  logic [FetchW-1:0] req_skip_q, req_skip_d;  // skip mask tagged onto the outstanding request
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;

  logic [PcW-1:0]      q_pc_q    [Depth];
  logic [FetchW*32-1:0] q_instr_q [Depth];
  logic [FetchW-1:0]   q_mask_q  [Depth];

  // ----------------------------------------------------------------------------------------------
  // Control
  // ----------------------------------------------------------------------------------------------
  logic              redirect;
  logic [PcW-1:0]    target;
  logic [FetchW-1:0] skip_tgt;
  logic [CntW-1:0]   occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  int unsigned       word_off;

  assign redirect = jump_i | branch_taken_i;
  assign target   = jump_i ? jump_address_i : branch_address_i;

  // Slots strictly below the target's word offset within its bundle are not executed.
  always_comb begin
    skip_tgt = '0;
    word_off = 32'(target[OffW-1:0]) >> 2;
    for (int unsigned i = 0; i < FetchW; i++) begin
      skip_tgt[i] = (i < word_off);
    end
  end

  // Queue entries plus the outstanding request never exceed Depth, so every response has a slot.
  assign occupancy = count_q + CntW'(inflight_q);
  assign issue     = rst_ni & en_i & ~redirect & (occupancy < DepthCnt);
  assign push      = inflight_q & ~redirect;
  assign pop       = out_valid_o & out_ready_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

  // ----------------------------------------------------------------------------------------------
  // Next state
  // ----------------------------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    skip_d     = skip_q;
    inflight_d = issue;
    req_pc_d   = req_pc_q;
    req_skip_d = req_skip_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      // Flush: the head may still be popped this cycle, but nothing survives it.
      pc_d       = target & AlignMask;
      skip_d     = skip_tgt;
      inflight_d = 1'b0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + BundleInc;
        req_pc_d   = pc_q;
        req_skip_d = skip_q;
        skip_d     = '0;
      end
      if (push) begin
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= ResetPc;
      skip_q     <= '0;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      req_skip_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      skip_q     <= skip_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      req_skip_q <= req_skip_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc_q[tail_q]    <= req_pc_q;
      q_instr_q[tail_q] <= imem_rdata_i;
      q_mask_q[tail_q]  <= ~req_skip_q;
    end
  end

  // ----------------------------------------------------------------------------------------------
  // Decode-facing outputs, forced to zero when the queue is empty
  // ----------------------------------------------------------------------------------------------
  assign out_valid_o = (count_q != '0);

  always_comb begin
    out_pc_o         = '0;
    out_pc_next_o    = '0;
    out_instr_o      = '0;
    out_slot_valid_o = '0;
    if (out_valid_o) begin
      out_pc_o         = q_pc_q[head_q];
      out_pc_next_o    = q_pc_q[head_q] + BundleInc;
      out_instr_o      = q_instr_q[head_q];
      out_slot_valid_o = q_mask_q[head_q];
    end
  end

endmodule

// File: tb/tb_if_fetch_queue_stage.sv
// ------------------------------------------------------------------------------------------------
// Directed bench for if_fetch_queue_stage (PcW=10, FetchW=2, Depth=4, ResetPc=0).
// A one-cycle-latency instruction memory returns, for bundle address a, the words
// {A5000000|(a+4), A5000000|a}, so every bundle is identifiable by its address.
// ------------------------------------------------------------------------------------------------
module tb_if_fetch_queue_stage;

  localparam int unsigned PcW    = 10;
  localparam int unsigned FetchW = 2;
  localparam int unsigned Depth  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 branch_taken;
  logic [PcW-1:0]       branch_address;
  logic                 jump;
  logic [PcW-1:0]       jump_address;
  logic                 imem_req;
  logic [PcW-1:0]       imem_addr;
  logic [FetchW*32-1:0] imem_rdata = '0;
  logic                 out_valid;
  logic                 out_ready;
  logic [PcW-1:0]       out_pc;
  logic [PcW-1:0]       out_pc_next;
  logic [FetchW*32-1:0] out_instr;
  logic [FetchW-1:0]    out_slot_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_queue_stage #(
    .PcW     (PcW),
    .FetchW  (FetchW),
    .Depth   (Depth),
    .ResetPc ('0)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .branch_taken_i   (branch_taken),
    .branch_address_i (branch_address),
    .jump_i           (jump),
    .jump_address_i   (jump_address),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_pc_o         (out_pc),
    .out_pc_next_o    (out_pc_next),
    .out_instr_o      (out_instr),
    .out_slot_valid_o (out_slot_valid)
  );

  function automatic logic [63:0] bund(input logic [PcW-1:0] a);
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = 32'hA500_0000 | 32'(a);
    w1 = 32'hA500_0000 | 32'(a + PcW'(4));
    return {w1, w0};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= bund(imem_addr);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    en             = 1'b1;
    out_ready      = 1'b1;
    jump           = 1'b0;
    jump_address   = '0;
    branch_taken   = 1'b0;
    branch_address = '0;

    // Reset state
    #3;
    check("rst_req",   64'(imem_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc",    64'(out_pc), 64'd0);
    check("rst_slot",  64'(out_slot_valid), 64'd0);
    check("rst_instr", out_instr, 64'd0);

    // Streaming from reset
    #5;
    rst_n = 1'b1;
    #1;
    check("s_req0",  64'(imem_req), 64'd1);
    check("s_addr0", 64'(imem_addr), 64'h0);
    tick;
    check("s_valid1", 64'(out_valid), 64'd0);
    check("s_addr1",  64'(imem_addr), 64'h8);
    tick;
    check("s_valid2", 64'(out_valid), 64'd1);
    check("s_pc2",    64'(out_pc), 64'h0);
    check("s_next2",  64'(out_pc_next), 64'h8);
    check("s_slot2",  64'(out_slot_valid), 64'h3);
    check("s_instr2", out_instr, bund(10'h0));
    check("s_addr2",  64'(imem_addr), 64'h10);
    tick;
    check("s_pc3",   64'(out_pc), 64'h8);
    check("s_addr3", 64'(imem_addr), 64'h18);

    // Backpressure: queue fills to Depth, then issue stops
    out_ready = 1'b0;
    repeat (10) tick;
    check("bp_req",   64'(imem_req), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_pc",    64'(out_pc), 64'h8);
    out_ready = 1'b1;
    tick;
    check("dr_pc16", 64'(out_pc), 64'h10);
    tick;
    check("dr_pc24", 64'(out_pc), 64'h18);
    tick;
    check("dr_pc32",    64'(out_pc), 64'h20);
    check("dr_instr32", out_instr, bund(10'h20));
    tick;
    check("dr_pc40", 64'(out_pc), 64'h28);

    // Jump to a misaligned target with three bundles queued
    out_ready = 1'b0;
    tick;
    check("j_pc_hold", 64'(out_pc), 64'h28);
    jump         = 1'b1;
    jump_address = 10'h14;
    #1;
    check("j_req_sup", 64'(imem_req), 64'd0);
    tick;
    jump = 1'b0;
    #1;
    check("j_valid_flush", 64'(out_valid), 64'd0);
    check("j_pc_zero",     64'(out_pc), 64'd0);
    check("j_req",         64'(imem_req), 64'd1);
    check("j_addr",        64'(imem_addr), 64'h10);
    tick;
    check("j_valid_lat", 64'(out_valid), 64'd0);
    check("j_addr2",     64'(imem_addr), 64'h18);
    tick;
    check("j_valid", 64'(out_valid), 64'd1);
    check("j_pc",    64'(out_pc), 64'h10);
    check("j_slot",  64'(out_slot_valid), 64'h2);
    check("j_instr", out_instr, bund(10'h10));

    // Jump and branch together, with a pop and an in-flight response in the redirect cycle
    out_ready      = 1'b1;
    jump           = 1'b1;
    jump_address   = 10'h40;
    branch_taken   = 1'b1;
    branch_address = 10'h80;
    #1;
    check("jb_req_sup", 64'(imem_req), 64'd0);
    check("jb_head",    64'(out_pc), 64'h10);
    tick;
    jump         = 1'b0;
    branch_taken = 1'b0;
    #1;
    check("jb_valid0", 64'(out_valid), 64'd0);
    check("jb_addr",   64'(imem_addr), 64'h40);
    tick;
    check("jb_valid1", 64'(out_valid), 64'd0);
    tick;
    check("jb_valid2", 64'(out_valid), 64'd1);
    check("jb_pc",     64'(out_pc), 64'h40);
    check("jb_slot",   64'(out_slot_valid), 64'h3);

    // Fetch disabled for five cycles: outstanding response still lands, queue drains
    en = 1'b0;
    #1;
    check("en_req0", 64'(imem_req), 64'd0);
    tick;
    check("en_pc48", 64'(out_pc), 64'h48);
    tick;
    check("en_empty", 64'(out_valid), 64'd0);
    repeat (3) tick;
    check("en_req_end",   64'(imem_req), 64'd0);
    check("en_valid_end", 64'(out_valid), 64'd0);
    check("en_pc_zero",   64'(out_pc), 64'd0);
    en = 1'b1;
    #1;
    check("en_resume_req",  64'(imem_req), 64'd1);
    check("en_resume_addr", 64'(imem_addr), 64'h50);
    tick;
    tick;
    check("en_resume_pc", 64'(out_pc), 64'h50);

    // PC wrap at the top of the address space
    jump         = 1'b1;
    jump_address = 10'h3F8;
    tick;
    jump = 1'b0;
    #1;
    check("w_addr", 64'(imem_addr), 64'h3F8);
    tick;
    check("w_addr_wrap", 64'(imem_addr), 64'h0);
    tick;
    check("w_pc",    64'(out_pc), 64'h3F8);
    check("w_next",  64'(out_pc_next), 64'h0);
    check("w_instr", out_instr, bund(10'h3F8));

    // Asynchronous reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_req",   64'(imem_req), 64'd0);
    check("ar_pc",    64'(out_pc), 64'd0);
    check("ar_slot",  64'(out_slot_valid), 64'd0);
    check("ar_instr", out_instr, 64'd0);
    tick;
    rst_n = 1'b1;
    #1;
    check("ar_restart_req",  64'(imem_req), 64'd1);
    check("ar_restart_addr", 64'(imem_addr), 64'h0);
    tick;
    tick;
    check("ar_restart_pc",   64'(out_pc), 64'h0);
    check("ar_restart_slot", 64'(out_slot_valid), 64'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
